// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM states, opcode
// constants, opcode classes and the datapath select encodings.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    // Instruction class, resolved from the opcode in DECODE and held for
    // the remainder of the instruction.
    typedef enum logic [2:0] {
        CLS_LW      = 3'd0,
        CLS_SW      = 3'd1,
        CLS_BEQ     = 3'd2,
        CLS_RTYPE   = 3'd3,
        CLS_ADDI    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } opc_class_e;

    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ADDI  = 7'b0010011;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    localparam logic WB_ALU = 1'b0;
    localparam logic WB_MEM = 1'b1;

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode classifier. ADDI support is enabled by defining
// the macro MC_CTRL_ADDI_EN; otherwise opcode 0010011 is illegal.
module mc_opcode_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0]  opcode,
    output opc_class_e  cls,
    output logic        legal
);

    // Map the 7-bit opcode onto an instruction class.
    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OPC_LW:    cls = CLS_LW;
            OPC_SW:    cls = CLS_SW;
            OPC_BEQ:   cls = CLS_BEQ;
            OPC_RTYPE: cls = CLS_RTYPE;
`ifdef MC_CTRL_ADDI_EN
            OPC_ADDI:  cls = CLS_ADDI;
`else
            OPC_ADDI:  cls = CLS_ILLEGAL;
`endif
            default:   cls = CLS_ILLEGAL;
        endcase
    end

    assign legal = (cls != CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Tracks retired instructions and traps on illegal opcodes or memory
// timeouts. ADDI support is enabled by defining MC_CTRL_ADDI_EN.
//
// Memory handshake: mem_req is held high (with stable mem_addr_sel and
// mem_we) for as long as the controller waits; the transfer completes in
// the cycle where mem_req=1 and mem_ready=1 at the rising edge. mem_ready
// is ignored while mem_req=0.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        pc_we,
    output logic        ir_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_we,
    output logic        mem_addr_sel,
    output logic        pc_src,
    output logic        wb_sel,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [2:0]  state,
    output logic        trap,
    output logic        illegal,
    output logic        timeout,
    output logic [31:0] retired
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    opc_class_e  cls_q;
    opc_class_e  dec_cls;
    logic        dec_legal;
    logic [CW-1:0] wait_q;
    logic        wait_hit;
    logic        retire;
    logic        ill_set, to_set;
    logic        illegal_q, timeout_q;
    logic [31:0] retired_q;

    // Upper instruction bits belong to the datapath (registers, immediates).
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[31:7];

    mc_opcode_decode u_decode (
        .opcode (instr[6:0]),
        .cls    (dec_cls),
        .legal  (dec_legal)
    );

    // The limit is reached on the cycle that would make the count equal
    // MEM_TIMEOUT; a simultaneous mem_ready completes the access instead.
    assign wait_hit = !mem_ready && (wait_q == WAIT_LAST);

    // Next-state and control outputs; reset forces every enable low at once.
    always_comb begin
        state_d      = state_q;
        pc_we        = 1'b0;
        ir_we        = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        reg_we       = 1'b0;
        mem_addr_sel = 1'b0;
        pc_src       = 1'b0;
        wb_sel       = WB_ALU;
        alu_src_b    = SRCB_REG;
        alu_op       = ALU_ADD;
        retire       = 1'b0;
        ill_set      = 1'b0;
        to_set       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_hit) begin
                    to_set  = 1'b1;
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    ill_set = 1'b1;
                    state_d = ST_TRAP;
                end
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_LW, CLS_SW: begin
                        alu_src_b = SRCB_IMM;
                        alu_op    = ALU_ADD;
                        state_d   = ST_MEM;
                    end
                    CLS_ADDI: begin
                        alu_src_b = SRCB_IMM;
                        alu_op    = ALU_ADD;
                        state_d   = ST_WB;
                    end
                    CLS_RTYPE: begin
                        alu_src_b = SRCB_REG;
                        alu_op    = ALU_FUNCT;
                        state_d   = ST_WB;
                    end
                    CLS_BEQ: begin
                        alu_src_b = SRCB_REG;
                        alu_op    = ALU_SUB;
                        pc_src    = 1'b1;
                        pc_we     = zero;
                        retire    = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    default: begin
                        ill_set = 1'b1;
                        state_d = ST_TRAP;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls_q == CLS_SW);
                if (mem_ready) begin
                    if (cls_q == CLS_SW) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_hit) begin
                    to_set  = 1'b1;
                    state_d = ST_TRAP;
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                wb_sel  = (cls_q == CLS_LW) ? WB_MEM : WB_ALU;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase
        if (rst) begin
            pc_we        = 1'b0;
            ir_we        = 1'b0;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            reg_we       = 1'b0;
            mem_addr_sel = 1'b0;
            pc_src       = 1'b0;
            wb_sel       = WB_ALU;
            alu_src_b    = SRCB_REG;
            alu_op       = ALU_ADD;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

    // Capture the instruction class as DECODE completes so later IR
    // changes cannot disturb EXEC/MEM/WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       cls_q <= CLS_ILLEGAL;
        else if (state_q == ST_DECODE) cls_q <= dec_cls;
    end

    // Memory wait counter: zero on every state change, counts stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else if (state_d != state_q) begin
            wait_q <= '0;
        end else if ((state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready) begin
            wait_q <= wait_q + CW'(1);
        end
    end

    // Sticky trap cause flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            illegal_q <= illegal_q | ill_set;
            timeout_q <= timeout_q | to_set;
        end
    end

    // Retired instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         retired_q <= 32'd0;
        else if (retire) retired_q <= retired_q + 32'd1;
    end

    assign state   = state_q;
    assign trap    = (state_q == ST_TRAP);
    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction table,
// hand-written timeout/trap/reset sequences and a randomized run against
// an instruction-plan reference model. Honours MC_CTRL_ADDI_EN.
module tb_multicycle_ctrl;
    import mc_ctrl_pkg::*;

    localparam int MEM_TIMEOUT = 15;

    localparam int C_LW = 0, C_SW = 1, C_BEQ = 2, C_R = 3, C_ADDI = 4, C_ILL = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        mem_ready = 1'b0;
    logic        zero = 1'b0;
    logic        pc_we, ir_we, mem_req, mem_we, reg_we;
    logic        mem_addr_sel, pc_src, wb_sel;
    logic [1:0]  alu_src_b, alu_op;
    logic [2:0]  state;
    logic        trap, illegal, timeout;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .zero         (zero),
        .pc_we        (pc_we),
        .ir_we        (ir_we),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .reg_we       (reg_we),
        .mem_addr_sel (mem_addr_sel),
        .pc_src       (pc_src),
        .wb_sel       (wb_sel),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .state        (state),
        .trap         (trap),
        .illegal      (illegal),
        .timeout      (timeout),
        .retired      (retired)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [17:0] act_vec;
    assign act_vec = {pc_we, ir_we, mem_req, mem_we, reg_we, mem_addr_sel,
                      pc_src, wb_sel, alu_src_b, alu_op, state, trap, illegal, timeout};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: an instruction is a plan of phases; waiting phases
    // (FETCH, MEM) advance only on mem_ready.
    state_e      plan[$];
    int          m_cls;
    int          m_wait;
    logic [31:0] m_ret;
    logic        m_ill, m_to;

    function automatic int classify(input logic [31:0] ins);
        case (ins[6:0])
            7'b0000011: return C_LW;
            7'b0100011: return C_SW;
            7'b1100011: return C_BEQ;
            7'b0110011: return C_R;
`ifdef MC_CTRL_ADDI_EN
            7'b0010011: return C_ADDI;
`endif
            default:    return C_ILL;
        endcase
    endfunction

    function automatic logic [17:0] exp_vec(input state_e ph, input int cls, input logic mr,
                                            input logic z, input logic ill, input logic to);
        logic pcw, irw, mrq, mw, rw, mas, pcs, wbs, tr;
        logic [1:0] sb, op;
        logic [2:0] st;
        {pcw, irw, mrq, mw, rw, mas, pcs, wbs, tr} = '0;
        sb = 2'd0;
        op = 2'd0;
        st = ph;
        case (ph)
            ST_FETCH: begin mrq = 1; sb = 2'd1; op = 2'd0; pcw = mr; irw = mr; end
            ST_EXEC: begin
                if (cls == C_LW || cls == C_SW || cls == C_ADDI) begin sb = 2'd2; op = 2'd0; end
                else if (cls == C_R) begin sb = 2'd0; op = 2'd2; end
                else if (cls == C_BEQ) begin sb = 2'd0; op = 2'd1; pcs = 1; pcw = z; end
            end
            ST_MEM:  begin mrq = 1; mas = 1; mw = (cls == C_SW); end
            ST_WB:   begin rw = 1; wbs = (cls == C_LW); end
            ST_TRAP: tr = 1;
            default: ;
        endcase
        return {pcw, irw, mrq, mw, rw, mas, pcs, wbs, sb, op, st, tr, ill, to};
    endfunction

    task automatic model_reset();
        plan.delete();
        plan.push_back(ST_FETCH);
        m_cls  = C_ILL;
        m_wait = 0;
        m_ret  = 32'd0;
        m_ill  = 1'b0;
        m_to   = 1'b0;
    endtask

    task automatic model_step(input logic mr, input logic [31:0] ins);
        state_e ph;
        ph = plan[0];
        case (ph)
            ST_FETCH, ST_MEM: begin
                if (mr) begin
                    void'(plan.pop_front());
                    m_wait = 0;
                    if (ph == ST_FETCH) plan.push_back(ST_DECODE);
                end else begin
                    m_wait++;
                    if (m_wait >= MEM_TIMEOUT) begin
                        plan.delete();
                        plan.push_back(ST_TRAP);
                        m_to = 1'b1;
                    end
                end
            end
            ST_DECODE: begin
                void'(plan.pop_front());
                m_cls = classify(ins);
                case (m_cls)
                    C_LW:  begin plan.push_back(ST_EXEC); plan.push_back(ST_MEM); plan.push_back(ST_WB); end
                    C_SW:  begin plan.push_back(ST_EXEC); plan.push_back(ST_MEM); end
                    C_BEQ: plan.push_back(ST_EXEC);
                    C_R, C_ADDI: begin plan.push_back(ST_EXEC); plan.push_back(ST_WB); end
                    default: begin plan.push_back(ST_TRAP); m_ill = 1'b1; end
                endcase
            end
            ST_EXEC, ST_WB: void'(plan.pop_front());
            default: ;
        endcase
        if (plan.size() == 0) begin
            m_ret = m_ret + 32'd1;
            plan.push_back(ST_FETCH);
            m_wait = 0;
        end
    endtask

    // Driver: reset pulse with checks on the held-reset and first-fetch cycles.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        zero = 1'b1;
        #1;
        check("reset_outputs", 64'(act_vec), 64'd0);
        check("reset_retired", 64'(retired), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        zero = 1'b0;
        #1;
        check("first_fetch_req", 64'({mem_req, state}), 64'({1'b1, 3'(ST_FETCH)}));
    endtask

    typedef struct {
        logic [31:0] ins;
        logic        z;
        int          cycles;
        int          reg_we_n;
        int          mem_we_n;
        int          exec_pc_we;
        logic        wbs;
        logic        ill;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input int idx, input vec_t v);
        int n, rw_n, mw_n, epw, wbs_bad;
        apply_reset();
        instr = v.ins;
        zero = v.z;
        mem_ready = 1'b1;
        n = 0; rw_n = 0; mw_n = 0; epw = 0; wbs_bad = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (state == ST_TRAP) break;
            if (n > 0 && state == ST_FETCH) break;
            if (reg_we) begin
                rw_n++;
                if (wb_sel !== v.wbs) wbs_bad++;
            end
            if (mem_we) mw_n++;
            if (state == ST_EXEC && pc_we) epw++;
            n++;
            @(negedge clk);
        end
        check($sformatf("vec%0d_cycles", idx), 64'(n), 64'(v.cycles));
        check($sformatf("vec%0d_reg_we", idx), 64'(rw_n), 64'(v.reg_we_n));
        check($sformatf("vec%0d_mem_we", idx), 64'(mw_n), 64'(v.mem_we_n));
        check($sformatf("vec%0d_exec_pc_we", idx), 64'(epw), 64'(v.exec_pc_we));
        check($sformatf("vec%0d_wb_sel", idx), 64'(wbs_bad), 64'd0);
        check($sformatf("vec%0d_trap_illegal", idx), 64'({trap, illegal}), 64'({v.ill, v.ill}));
        check($sformatf("vec%0d_retired", idx), 64'(retired), v.ill ? 64'd0 : 64'd1);
    endtask

    initial begin
        int trap_n, trap_wait, sel;
        logic [31:0] r;
        logic [6:0] opc;

        vecs[0] = '{32'h00002083, 1'b0, 5, 1, 0, 0, 1'b1, 1'b0};  // LW
        vecs[1] = '{32'h00102023, 1'b0, 4, 0, 1, 0, 1'b0, 1'b0};  // SW
        vecs[2] = '{32'h00000063, 1'b1, 3, 0, 0, 1, 1'b0, 1'b0};  // BEQ taken
        vecs[3] = '{32'h00000063, 1'b0, 3, 0, 0, 0, 1'b0, 1'b0};  // BEQ not taken
        vecs[4] = '{32'h002081B3, 1'b0, 4, 1, 0, 0, 1'b0, 1'b0};  // R-type
`ifdef MC_CTRL_ADDI_EN
        vecs[5] = '{32'h00100093, 1'b0, 4, 1, 0, 0, 1'b0, 1'b0};  // ADDI legal
`else
        vecs[5] = '{32'h00100093, 1'b0, 2, 0, 0, 0, 1'b0, 1'b1};  // ADDI traps
`endif
        vecs[6] = '{32'hFFFFFF80, 1'b0, 2, 0, 0, 0, 1'b0, 1'b1};  // illegal

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Illegal trap is held for 20 cycles whatever the inputs do.
        apply_reset();
        instr = 32'hFFFFFF80;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        trap_n = 0;
        for (int k = 0; k < 20; k++) begin
            mem_ready = 1'($urandom_range(0, 1));
            instr = $urandom;
            #1;
            if (trap && illegal && !timeout && state == ST_TRAP && !mem_req && !pc_we) trap_n++;
            @(negedge clk);
        end
        check("illegal_trap_held", 64'(trap_n), 64'd20);

        // Fetch timeout: 15 stalled cycles trap, 14 do not.
        apply_reset();
        for (int k = 0; k < 14; k++) @(negedge clk);
        #1;
        check("timeout_not_early", 64'({state, trap}), 64'({3'(ST_FETCH), 1'b0}));
        @(negedge clk);
        #1;
        check("timeout_trap", 64'({state, trap, timeout, illegal}), 64'({3'(ST_TRAP), 1'b1, 1'b1, 1'b0}));

        apply_reset();
        for (int k = 0; k < 14; k++) @(negedge clk);
        mem_ready = 1'b1;
        instr = 32'h00002083;
        @(negedge clk);
        #1;
        check("ready_at_limit", 64'({state, trap, timeout}), 64'({3'(ST_DECODE), 1'b0, 1'b0}));

        // Asynchronous reset in the MEM phase of an LW.
        apply_reset();
        instr = 32'h002081B3;
        mem_ready = 1'b1;
        for (int k = 0; k < 10 && retired == 32'd0; k++) @(negedge clk);
        instr = 32'h00002083;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (state == ST_MEM) break;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        check("mem_req_in_mem", 64'({state, mem_req, mem_addr_sel, retired}),
              64'({3'(ST_MEM), 1'b1, 1'b1, 32'd1}));
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_mem", 64'({mem_req, mem_we, state, retired}),
              64'({1'b0, 1'b0, 3'(ST_FETCH), 32'd0}));

        // Randomized run against the plan model.
        apply_reset();
        model_reset();
        trap_wait = 0;
        for (int c = 0; c < 800; c++) begin
            if (plan[0] == ST_TRAP) begin
                trap_wait++;
                if (trap_wait > 3) begin
                    apply_reset();
                    model_reset();
                    trap_wait = 0;
                end
            end
            if (plan[0] == ST_FETCH) begin
                r = $urandom;
                sel = $urandom_range(0, 9);
                case (sel)
                    0, 1: opc = 7'b0000011;
                    2, 3: opc = 7'b0100011;
                    4:    opc = 7'b1100011;
                    5, 6: opc = 7'b0110011;
                    7, 8: opc = 7'b0010011;
                    default: opc = r[6:0];
                endcase
                instr = {r[31:7], opc};
            end else if (plan[0] != ST_DECODE) begin
                instr = $urandom;
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            zero = 1'($urandom_range(0, 1));
            #1;
            check("rand_outputs", 64'(act_vec), 64'(exp_vec(plan[0], m_cls, mem_ready, zero, m_ill, m_to)));
            check("rand_retired", 64'(retired), 64'(m_ret));
            model_step(mem_ready, instr);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
